// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the async FIFO: syncs the write pointer, owns the read pointer,
// and feeds a 2-entry output buffer that is presented to the consumer via valid/ready.
module fifo_rd_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 3
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [PTR_WIDTH:0]    g_wptr,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  r_en,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    rd_level,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] PtrOne = 1;

    logic [PTR_WIDTH:0]    wq1_q, wq2_q, wq2_bin;
    logic [PTR_WIDTH:0]    b_rptr_q, b_rptr_d, g_rptr_q, g_rptr_d;
    logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pop, drain;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wq2_bin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wq2_bin[i] = ^(wq2_q >> i);
        end
    end

    assign empty     = (g_rptr_q == wq2_q);
    assign out_valid = (occ_q != 2'd0);
    // Pop depends on registered state only, so out_ready never reaches the memory side.
    assign pop       = !empty && (occ_q != 2'd2);
    assign drain     = out_valid && out_ready;

    assign r_en     = pop;
    assign b_rptr   = b_rptr_q;
    assign g_rptr   = g_rptr_q;
    assign rd_level = wq2_bin - b_rptr_q;
    assign out_data = e0_q;

    always_comb begin
        b_rptr_d = pop ? (b_rptr_q + PtrOne) : b_rptr_q;
        g_rptr_d = b_rptr_d ^ (b_rptr_d >> 1);
    end

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({pop, drain})
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    e0_d = fifo_rdata;
                end else begin
                    e1_d = fifo_rdata;
                end
                occ_d = occ_q + 2'd1;
            end
            // Pop with drain only happens at occ==1: the new word replaces the head.
            2'b11: e0_d = fifo_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wq1_q    <= '0;
            wq2_q    <= '0;
            b_rptr_q <= '0;
            g_rptr_q <= '0;
            e0_q     <= '0;
            e1_q     <= '0;
            occ_q    <= 2'd0;
        end else begin
            wq1_q    <= g_wptr;
            wq2_q    <= wq1_q;
            b_rptr_q <= b_rptr_d;
            g_rptr_q <= g_rptr_d;
            e0_q     <= e0_d;
            e1_q     <= e1_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a word-count/queue model of the read side checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [3:0] g_wptr;
    logic [7:0] fifo_rdata;
    logic [3:0] b_rptr, g_rptr, rd_level;
    logic       r_en, empty, out_valid, out_ready;
    logic [7:0] out_data;

    fifo_rd_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(3)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .g_wptr     (g_wptr),
        .fifo_rdata (fifo_rdata),
        .b_rptr     (b_rptr),
        .g_rptr     (g_rptr),
        .r_en       (r_en),
        .empty      (empty),
        .rd_level   (rd_level),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 rclk = ~rclk;

    // Memory and write side live in the bench.
    logic [7:0] mem [8];
    assign fifo_rdata = mem[b_rptr[2:0]];

    int total = 0;
    int bad   = 0;

    int         wcount = 0;
    logic [7:0] hist[$];

    // Model: write count seen through two rclk stages, words popped, and the buffer as a queue.
    int         ws1 = 0, ws2 = 0, rcount = 0;
    logic [7:0] mq[$];
    bit         m_pop, m_drain, e_empty;

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge rclk);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        mem[wcount % 8] = d;
        hist.push_back(d);
        wcount++;
        g_wptr = gray(wcount);
    endtask

    task automatic assert_rst();
        #2;
        rrst_n    = 1'b0;
        wcount    = 0;
        g_wptr    = 4'd0;
        out_ready = 1'b0;
        hist.delete();
        #1;
    endtask

    task automatic release_rst();
        step();
        step();
        rrst_n = 1'b1;
    endtask

    task automatic drain_wait(input int budget);
        out_ready = 1'b1;
        for (int c = 0; c < budget && !(rcount == wcount && mq.size() == 0); c++) step();
        chk("drain_done", 32'({empty, out_valid}), 'b10);
    endtask

    initial begin
        forever begin
            @(posedge rclk or negedge rrst_n);
            if (!rrst_n) begin
                ws1 = 0;
                ws2 = 0;
                rcount = 0;
                mq.delete();
            end else begin
                m_pop   = (ws2 != rcount) && (mq.size() < 2);
                m_drain = (mq.size() > 0) && out_ready;
                if (m_drain) void'(mq.pop_front());
                if (m_pop) begin
                    mq.push_back(hist[rcount]);
                    rcount++;
                end
                ws2 = ws1;
                ws1 = wcount;
            end
        end
    end

    initial begin
        forever begin
            @(negedge rclk);
            if (rrst_n === 1'b1) begin
                e_empty = (ws2 == rcount);
                chk("empty", 32'(empty), 32'(e_empty));
                chk("r_en", 32'(r_en), 32'(!e_empty && mq.size() < 2));
                chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
                chk("b_rptr", 32'(b_rptr), 32'(rcount % 16));
                chk("g_rptr", 32'(g_rptr), 32'(gray(rcount)));
                chk("rd_level", 32'(rd_level), 32'(ws2 - rcount));
                if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int first, last;
        rrst_n    = 1'b0;
        out_ready = 1'b0;
        g_wptr    = 4'd0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_level", 32'(rd_level), 0);
        chk("rst_r_en", 32'(r_en), 0);
        rrst_n = 1'b1;

        // First word
        write(8'hA5);
        step();
        chk("t2_empty_n", 32'(empty), 1);
        step();
        chk("t2_empty_n1", 32'(empty), 0);
        chk("t2_r_en", 32'(r_en), 1);
        chk("t2_valid_early", 32'(out_valid), 0);
        step();
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_data", 32'(out_data), 'hA5);
        chk("t2_b_rptr", 32'(b_rptr), 1);
        chk("t2_g_rptr", 32'(g_rptr), 1);
        chk("t2_empty_again", 32'(empty), 1);

        // Asynchronous reset in the middle of a cycle with a word buffered
        assert_rst();
        chk("t1_valid", 32'(out_valid), 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_b_rptr", 32'(b_rptr), 0);
        chk("t1_g_rptr", 32'(g_rptr), 0);
        release_rst();

        // Backpressure
        write(8'h11);
        write(8'h22);
        write(8'h33);
        write(8'h44);
        repeat (6) step();
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_hold", 32'(out_data), 'h11);
        chk("t3_b_rptr", 32'(b_rptr), 2);
        chk("t3_r_en", 32'(r_en), 0);
        out_ready = 1'b1;
        step();
        chk("t3_w2", 32'(out_data), 'h22);
        step();
        chk("t3_w3", 32'(out_data), 'h33);
        step();
        chk("t3_w4", 32'(out_data), 'h44);
        chk("t3_w4_valid", 32'(out_valid), 1);
        step();
        chk("t3_done", 32'(out_valid), 0);

        // Streaming 16 words through a pointer wrap
        assert_rst();
        release_rst();
        out_ready = 1'b1;
        first = -1;
        last  = -1;
        for (int c = 0; c < 30; c++) begin
            if (wcount < 16) write(8'h30 + 8'(wcount));
            step();
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("t4_span", 32'(last - first + 1), 16);
        chk("t4_b_rptr", 32'(b_rptr), 0);
        chk("t4_g_rptr", 32'(g_rptr), 0);
        chk("t4_empty", 32'(empty), 1);

        // Full memory
        assert_rst();
        release_rst();
        for (int i = 0; i < 8; i++) write(8'hC0 + 8'(i));
        step();
        chk("t5_empty_n", 32'(empty), 1);
        chk("t5_level_n", 32'(rd_level), 0);
        step();
        chk("t5_empty", 32'(empty), 0);
        chk("t5_level", 32'(rd_level), 8);
        chk("t5_b_rptr", 32'(b_rptr), 0);
        drain_wait(40);
        chk("t5_level_end", 32'(rd_level), 0);
        chk("t5_empty_end", 32'(empty), 1);

        // Random consumer with 200 words
        assert_rst();
        release_rst();
        for (int c = 0; c < 3000 && wcount < 200; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ((wcount - rcount) < 8 && $urandom_range(0, 3) != 0) write(8'($urandom));
            step();
        end
        drain_wait(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
